// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_RUN  = 2'd1,
        IF_HALT = 2'd2
    } if_state_e;

    localparam logic [31:0] IF_HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] IF_NOP_WORD  = 32'h0000_0000;
    localparam logic [31:0] IF_PC_STEP   = 32'd4;

endpackage

// File: rtl/instruction_fetch_if.sv
// Control/load/fetch bundle between the debug unit, hazard/branch logic and IF.
interface instruction_fetch_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              i_load_en;
    logic [ADDR_W-1:0] i_load_addr;
    logic [DATA_W-1:0] i_load_data;
    logic              i_start;
    logic              i_enable;
    logic              i_stall;
    logic              i_redirect;
    logic [DATA_W-1:0] i_target;
    logic [DATA_W-1:0] o_pc;
    logic [DATA_W-1:0] o_instruction;
    logic              o_halted;
    logic [1:0]        o_state;

    modport master (
        output i_load_en, i_load_addr, i_load_data, i_start, i_enable,
               i_stall, i_redirect, i_target,
        input  o_pc, o_instruction, o_halted, o_state
    );

    modport slave (
        input  i_load_en, i_load_addr, i_load_data, i_start, i_enable,
               i_stall, i_redirect, i_target,
        output o_pc, o_instruction, o_halted, o_state
    );
endinterface

// File: rtl/instruction_fetch_instr_mem.sv
// Word-addressed instruction memory: one synchronous write, one async read.
// Contents are intentionally not reset so a loaded program survives rst.
module instr_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // Program-load write port
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/instruction_fetch.sv
// MIPS IF stage: PC register, IDLE/RUN/HALT FSM, instruction memory.
// Optional macro IF_STEP_MODE_EN: i_enable becomes a rising-edge step request.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int               DATA_W    = 32,
    parameter int               MEM_DEPTH = 256,
    parameter int               ADDR_W    = 8,
    parameter logic [DATA_W-1:0] HALT_WORD = IF_HALT_WORD
) (
    input  logic          clk,
    input  logic          rst,
    instruction_fetch_if.slave bus
);
    if (MEM_DEPTH != (1 << ADDR_W)) begin : g_depth_check
        $error("MEM_DEPTH must equal 2**ADDR_W");
    end

    if_state_e         state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] mem_word;
    logic              step;
    logic              mem_we;
    logic              unused_tgt;

    // Low target bits are dropped: redirects are always word aligned.
    assign unused_tgt = ^bus.i_target[1:0];

`ifdef IF_STEP_MODE_EN
    logic en_q, en_d;

    // Remember last i_enable so only its rising edge counts as a step
    always_comb en_d = bus.i_enable;

    // Step-request edge detector register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) en_q <= 1'b0;
        else     en_q <= en_d;
    end

    assign step = bus.i_enable & ~en_q;
`else
    assign step = bus.i_enable;
`endif

    // Loads only land while idle so a running program cannot be corrupted
    assign mem_we = bus.i_load_en && (state_q == IF_IDLE);

    instr_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (bus.i_load_addr),
        .wdata (bus.i_load_data),
        .raddr (pc_q[ADDR_W+1:2]),
        .rdata (mem_word)
    );

    // State and PC registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IF_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state / next PC: redirect beats stall; HALT word freezes the PC
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IF_IDLE: begin
                if (bus.i_start && bus.i_enable) state_d = IF_RUN;
            end
            IF_RUN: begin
                if (step) begin
                    if (bus.i_redirect) begin
                        pc_d = {bus.i_target[DATA_W-1:2], 2'b00};
                    end else if (!bus.i_stall) begin
                        if (mem_word == HALT_WORD) state_d = IF_HALT;
                        else                       pc_d = pc_q + DATA_W'(IF_PC_STEP);
                    end
                end
            end
            IF_HALT: begin
                state_d = IF_HALT;
            end
            default: begin
                state_d = IF_IDLE;
            end
        endcase
    end

    // Outputs toward the IF/ID latch and debug readout
    always_comb begin
        bus.o_pc          = pc_q + DATA_W'(IF_PC_STEP);
        bus.o_instruction = (state_q == IF_HALT) ? HALT_WORD : mem_word;
        bus.o_halted      = (state_q == IF_HALT);
        bus.o_state       = state_q;
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: stimulus pushes expected outputs,
// a negedge monitor pops and compares.
module tb_instruction_fetch;
    logic clk = 1'b0;
    logic rst;

    instruction_fetch_if #(.DATA_W(32), .ADDR_W(8)) bus();

    instruction_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] opc;
        logic [31:0] ins;
        bit          ci;
        logic [1:0]  st;
        logic        halted;
        int          tag;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int tag_n  = 0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;
    localparam logic [31:0] HW    = 32'hFFFF_FFFF;

    // Monitor: compare DUT outputs against the oldest expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (bus.o_pc !== e.opc || bus.o_state !== e.st || bus.o_halted !== e.halted ||
                (e.ci && bus.o_instruction !== e.ins)) begin
                errors++;
                $display("FAIL step%0d: got pc=%h ins=%h st=%0d halted=%0b, want pc=%h ins=%h st=%0d halted=%0b",
                         e.tag, bus.o_pc, bus.o_instruction, bus.o_state, bus.o_halted,
                         e.opc, e.ins, e.st, e.halted);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect, for the current cycle, internal pc 'pc' (o_pc = pc+4)
    task automatic expect_now(input logic [31:0] pc, input logic [31:0] ins,
                              input bit ci, input logic [1:0] st);
        exp_t e;
        e.opc    = pc + 32'd4;
        e.ins    = ins;
        e.ci     = ci;
        e.st     = st;
        e.halted = (st == S_HALT);
        e.tag    = tag_n;
        tag_n++;
        exp_q.push_back(e);
    endtask

    task automatic load_word(input logic [7:0] a, input logic [31:0] d);
        tick();
        bus.i_load_en   = 1'b1;
        bus.i_load_addr = a;
        bus.i_load_data = d;
        expect_now(32'd0, 32'd0, 1'b0, S_IDLE);
    endtask

`ifdef IF_STEP_MODE_EN
    initial begin
        rst = 1'b1;
        bus.i_load_en = 0; bus.i_load_addr = '0; bus.i_load_data = '0;
        bus.i_start = 0; bus.i_enable = 0; bus.i_stall = 0;
        bus.i_redirect = 0; bus.i_target = '0;
        #2;
        expect_now(32'd0, 32'd0, 1'b0, S_IDLE);
        tick(); rst = 1'b0;
        for (int i = 0; i < 6; i++) load_word(8'(i), 32'h100 + 32'(i));
        tick(); bus.i_load_en = 0; expect_now(0, 32'h100, 1, S_IDLE);
        tick(); bus.i_start = 1; bus.i_enable = 1; expect_now(0, 32'h100, 1, S_IDLE);
        tick(); bus.i_start = 0; bus.i_enable = 0; expect_now(0, 32'h100, 1, S_RUN);
        // Enable held high for 5 cycles: exactly one step
        tick(); bus.i_enable = 1; expect_now(0, 32'h100, 1, S_RUN);
        for (int i = 0; i < 4; i++) begin
            tick(); expect_now(4, 32'h101, 1, S_RUN);
        end
        // Three toggles: three more steps
        tick(); bus.i_enable = 0; expect_now(4,  32'h101, 1, S_RUN);
        tick(); bus.i_enable = 1; expect_now(4,  32'h101, 1, S_RUN);
        tick(); bus.i_enable = 0; expect_now(8,  32'h102, 1, S_RUN);
        tick(); bus.i_enable = 1; expect_now(8,  32'h102, 1, S_RUN);
        tick(); bus.i_enable = 0; expect_now(12, 32'h103, 1, S_RUN);
        tick(); bus.i_enable = 1; expect_now(12, 32'h103, 1, S_RUN);
        tick(); bus.i_enable = 0; expect_now(16, 32'h104, 1, S_RUN);
        // Stall applied on a step cycle holds the PC
        tick(); bus.i_enable = 1; bus.i_stall = 1; expect_now(16, 32'h104, 1, S_RUN);
        tick(); bus.i_enable = 0; bus.i_stall = 0; expect_now(16, 32'h104, 1, S_RUN);
        tick(); expect_now(16, 32'h104, 1, S_RUN);
        finish_run();
    end
`else
    initial begin
        rst = 1'b1;
        bus.i_load_en = 0; bus.i_load_addr = '0; bus.i_load_data = '0;
        bus.i_start = 0; bus.i_enable = 0; bus.i_stall = 0;
        bus.i_redirect = 0; bus.i_target = '0;
        #2;
        expect_now(32'd0, 32'd0, 1'b0, S_IDLE);
        tick(); rst = 1'b0;
        load_word(8'd0,   32'h2001_0005);
        load_word(8'd1,   32'h2002_0003);
        load_word(8'd2,   32'h0022_1820);
        load_word(8'd3,   HW);
        load_word(8'd16,  32'h1234_5678);
        load_word(8'd17,  HW);
        load_word(8'd255, 32'hA5A5_A5A5);
        tick(); bus.i_load_en = 0; expect_now(0, 32'h2001_0005, 1, S_IDLE);

        // Run 1: straight-line program up to HALT
        tick(); bus.i_start = 1; bus.i_enable = 1; expect_now(0, 32'h2001_0005, 1, S_IDLE);
        tick(); bus.i_start = 0; expect_now(0,  32'h2001_0005, 1, S_RUN);
        tick(); expect_now(4,  32'h2002_0003, 1, S_RUN);
        tick(); expect_now(8,  32'h0022_1820, 1, S_RUN);
        tick(); expect_now(12, HW, 1, S_RUN);
        tick(); expect_now(12, HW, 1, S_HALT);
        tick(); expect_now(12, HW, 1, S_HALT);
        // Reset from HALT, checked before any clock edge
        tick(); rst = 1; expect_now(0, 32'h2001_0005, 1, S_IDLE);
        tick(); rst = 0; expect_now(0, 32'h2001_0005, 1, S_IDLE);

        // Run 2: blocked load during RUN, 3-cycle stall, async reset at pc=12
        tick(); bus.i_start = 1; expect_now(0, 32'h2001_0005, 1, S_IDLE);
        tick(); bus.i_start = 0;
        bus.i_load_en = 1; bus.i_load_addr = 8'd1; bus.i_load_data = 32'd0;
        expect_now(0, 32'h2001_0005, 1, S_RUN);
        tick(); bus.i_load_en = 0; expect_now(4, 32'h2002_0003, 1, S_RUN);
        tick(); bus.i_stall = 1; expect_now(8, 32'h0022_1820, 1, S_RUN);
        tick(); expect_now(8, 32'h0022_1820, 1, S_RUN);
        tick(); expect_now(8, 32'h0022_1820, 1, S_RUN);
        tick(); bus.i_stall = 0; expect_now(8, 32'h0022_1820, 1, S_RUN);
        tick(); expect_now(12, HW, 1, S_RUN);
        @(negedge clk);
        #2;
        rst = 1;
        #1;
        checks++;
        if (bus.o_state !== S_IDLE || bus.o_pc !== 32'd4) begin
            errors++;
            $display("FAIL async_rst: got st=%0d pc=%h, want st=0 pc=00000004", bus.o_state, bus.o_pc);
        end
        tick(); rst = 0; expect_now(0, 32'h2001_0005, 1, S_IDLE);

        // Run 3: enable gating, redirect+stall, HALT-cycle redirect, wrap-around
        tick(); bus.i_start = 1; expect_now(0, 32'h2001_0005, 1, S_IDLE);
        tick(); bus.i_start = 0; expect_now(0, 32'h2001_0005, 1, S_RUN);
        tick(); bus.i_enable = 0; expect_now(4, 32'h2002_0003, 1, S_RUN);
        tick(); expect_now(4, 32'h2002_0003, 1, S_RUN);
        tick(); bus.i_enable = 1; expect_now(4, 32'h2002_0003, 1, S_RUN);
        tick(); bus.i_redirect = 1; bus.i_target = 32'h41; bus.i_stall = 1;
        expect_now(8, 32'h0022_1820, 1, S_RUN);
        tick(); bus.i_redirect = 0; bus.i_stall = 0; expect_now(32'h40, 32'h1234_5678, 1, S_RUN);
        tick(); bus.i_redirect = 1; bus.i_target = 32'h400; expect_now(32'h44, HW, 1, S_RUN);
        tick(); bus.i_redirect = 0; expect_now(32'h400, 32'h2001_0005, 1, S_RUN);
        tick(); bus.i_redirect = 1; bus.i_target = 32'hFFFF_FFFC; expect_now(32'h404, 32'h2002_0003, 1, S_RUN);
        tick(); bus.i_redirect = 0; expect_now(32'hFFFF_FFFC, 32'hA5A5_A5A5, 1, S_RUN);
        tick(); expect_now(0,  32'h2001_0005, 1, S_RUN);
        tick(); expect_now(4,  32'h2002_0003, 1, S_RUN);
        tick(); expect_now(8,  32'h0022_1820, 1, S_RUN);
        tick(); expect_now(12, HW, 1, S_RUN);
        tick(); expect_now(12, HW, 1, S_HALT);
        finish_run();
    end
`endif

    task automatic finish_run();
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask
endmodule
